// File: rtl/epd_pkg.sv
// Shared types for the e-paper scan sequencer.
//   epd_state_e   : scan FSM states
//   epd_ctl_t     : panel control bundle (cl, le, oe, sph, ckv, spv, gmode)
//   CTL_IDLE      : control values while idle or in reset (start pulses inactive high)
//   ctl_for_state : control bundle driven while the FSM sits in a given state
package epd_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FS1,
    FS2,
    LD_A,
    LD_B,
    LATCH,
    GATE,
    GATE_LO,
    FE,
    DONE
  } epd_state_e;

  typedef struct packed {
    logic cl;
    logic le;
    logic oe;
    logic sph;
    logic ckv;
    logic spv;
    logic gmode;
  } epd_ctl_t;

  localparam logic SPV_IDLE = 1'b1;
  localparam logic SPH_IDLE = 1'b1;

  localparam epd_ctl_t CTL_IDLE = '{
    cl:    1'b0,
    le:    1'b0,
    oe:    1'b0,
    sph:   SPH_IDLE,
    ckv:   1'b0,
    spv:   SPV_IDLE,
    gmode: 1'b0
  };

  // Panel control levels for each state; gmode follows busy.
  function automatic epd_ctl_t ctl_for_state(input epd_state_e s);
    epd_ctl_t c;
    c       = CTL_IDLE;
    c.gmode = (s != IDLE) && (s != DONE);
    case (s)
      FS1: begin
        c.spv = 1'b0;
        c.ckv = 1'b1;
      end
      LD_A: c.sph = 1'b0;
      LD_B: begin
        c.sph = 1'b0;
        c.cl  = 1'b1;
      end
      LATCH: c.le = 1'b1;
      GATE: begin
        c.ckv = 1'b1;
        c.oe  = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/epd_tick_gen.sv
// Timing tick prescaler: one tick every CL_DIV clocks while enabled.
//   clock, reset_n : system clock, synchronous active-low reset
//   clear          : restart the count at 0 (aligns the first tick after a start)
//   enable         : count only while a refresh is running
//   tick_c         : combinational tick, high on the last clock of each period
module epd_tick_gen #(
  parameter int unsigned CL_DIV = 12
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tick_c
);

  localparam int unsigned CNT_W = (CL_DIV > 1) ? $clog2(CL_DIV) : 1;

  logic [CNT_W-1:0] count;

  assign tick_c = enable && (count == CNT_W'(CL_DIV - 1));

  // Period counter, wraps on tick.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick_c ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/epd_scan_ctrl.sv
// E-paper frame/line scan sequencer.
//   clock, reset_n        : system clock, synchronous active-low reset
//   start, frames         : refresh request (rising edge) and frame count (0 = 1)
//   pix_data, data_valid  : upstream pixel byte stream
//   data_ready            : byte consumed this cycle (combinational, same-cycle handshake)
//   busy, done            : refresh in progress / one-clock completion pulse
//   epd_d, epd_cl, epd_le, epd_oe, epd_sph : source driver interface
//   epd_ckv, epd_spv, epd_gmode            : gate driver interface
module epd_scan_ctrl
  import epd_pkg::*;
#(
  parameter int unsigned H_BYTES   = 200,
  parameter int unsigned V_LINES   = 600,
  parameter int unsigned CL_DIV    = 12,
  parameter int unsigned CKV_TICKS = 2,
  parameter int unsigned FRAME_W   = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [FRAME_W-1:0] frames,
  input  logic [7:0]         pix_data,
  input  logic               data_valid,
  output logic               data_ready,
  output logic               busy,
  output logic               done,
  output logic [7:0]         epd_d,
  output logic               epd_cl,
  output logic               epd_le,
  output logic               epd_oe,
  output logic               epd_sph,
  output logic               epd_ckv,
  output logic               epd_spv,
  output logic               epd_gmode
);

  localparam int unsigned BYTE_W = (H_BYTES > 1) ? $clog2(H_BYTES) : 1;
  localparam int unsigned LINE_W = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam int unsigned GATE_W = (CKV_TICKS > 1) ? $clog2(CKV_TICKS) : 1;

  epd_state_e         state, state_n;
  logic [BYTE_W-1:0]  byte_cnt, byte_n;
  logic [LINE_W-1:0]  line_cnt, line_n;
  logic [GATE_W-1:0]  gate_cnt, gate_n;
  logic [FRAME_W-1:0] frame_cnt, frame_n;
  logic [FRAME_W-1:0] frames_lat, frames_lat_n;
  epd_ctl_t           ctl, ctl_n;
  logic               start_q;
  logic               accept;
  logic               tick;

  // Tracks start even during reset, so a level held across reset is not an edge.
  always_ff @(posedge clock) begin
    start_q <= start;
  end

  assign accept = start && !start_q && (state == IDLE);

  epd_tick_gen #(
    .CL_DIV (CL_DIV)
  ) u_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (accept),
    .enable  (busy),
    .tick_c  (tick)
  );

  // State register, counters and registered panel outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      line_cnt   <= '0;
      gate_cnt   <= '0;
      frame_cnt  <= '0;
      frames_lat <= '0;
      ctl        <= CTL_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      epd_d      <= '0;
    end else begin
      state      <= state_n;
      byte_cnt   <= byte_n;
      line_cnt   <= line_n;
      gate_cnt   <= gate_n;
      frame_cnt  <= frame_n;
      frames_lat <= frames_lat_n;
      ctl        <= ctl_n;
      busy       <= ctl_n.gmode;
      done       <= (state_n == DONE);
      if (data_ready) begin
        epd_d <= pix_data;
      end
    end
  end

  // Next-state, counter updates and pixel handshake; all moves on tick except DONE.
  always_comb begin
    state_n      = state;
    byte_n       = byte_cnt;
    line_n       = line_cnt;
    gate_n       = gate_cnt;
    frame_n      = frame_cnt;
    frames_lat_n = frames_lat;
    data_ready   = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          frame_n      = '0;
          frames_lat_n = (frames == '0) ? FRAME_W'(1) : frames;
          state_n      = FS1;
        end
      end
      FS1: begin
        if (tick) state_n = FS2;
      end
      FS2: begin
        if (tick) begin
          line_n  = '0;
          byte_n  = '0;
          state_n = LD_A;
        end
      end
      LD_A: begin
        // Stall here indefinitely until upstream has a byte on a tick.
        if (tick && data_valid) begin
          data_ready = 1'b1;
          state_n    = LD_B;
        end
      end
      LD_B: begin
        if (tick) begin
          if (byte_cnt == BYTE_W'(H_BYTES - 1)) begin
            byte_n  = '0;
            state_n = LATCH;
          end else begin
            byte_n  = byte_cnt + BYTE_W'(1);
            state_n = LD_A;
          end
        end
      end
      LATCH: begin
        if (tick) begin
          gate_n  = '0;
          state_n = GATE;
        end
      end
      GATE: begin
        if (tick) begin
          if (gate_cnt == GATE_W'(CKV_TICKS - 1)) begin
            gate_n  = '0;
            state_n = GATE_LO;
          end else begin
            gate_n = gate_cnt + GATE_W'(1);
          end
        end
      end
      GATE_LO: begin
        if (tick) begin
          if (line_cnt == LINE_W'(V_LINES - 1)) begin
            line_n  = '0;
            state_n = FE;
          end else begin
            line_n  = line_cnt + LINE_W'(1);
            state_n = LD_A;
          end
        end
      end
      FE: begin
        if (tick) begin
          if (frame_cnt == frames_lat - FRAME_W'(1)) begin
            frame_n = '0;
            state_n = DONE;
          end else begin
            frame_n = frame_cnt + FRAME_W'(1);
            state_n = FS1;
          end
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    ctl_n = ctl_for_state(state_n);
  end

  assign epd_cl    = ctl.cl;
  assign epd_le    = ctl.le;
  assign epd_oe    = ctl.oe;
  assign epd_sph   = ctl.sph;
  assign epd_ckv   = ctl.ckv;
  assign epd_spv   = ctl.spv;
  assign epd_gmode = ctl.gmode;

endmodule

// File: tb/tb_epd_scan_ctrl.sv
// Self-checking bench for epd_scan_ctrl: a small-geometry instance exercised with
// random and directed pixel streams, plus a default-prescaler instance for timing.
module tb_epd_scan_ctrl;

  localparam int unsigned T_CL    = 2;
  localparam int unsigned T_H     = 4;
  localparam int unsigned T_V     = 3;
  localparam int unsigned T_CKV   = 2;
  localparam int unsigned T_TICKS = 2 + T_V * (2 * T_H + 1 + T_CKV + 1) + 1;
  localparam int          LIMIT   = 5000;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic [7:0] frames;
  logic [7:0] pix_data;
  logic       data_valid;
  logic       data_ready, busy, done;
  logic [7:0] epd_d;
  logic       epd_cl, epd_le, epd_oe, epd_sph, epd_ckv, epd_spv, epd_gmode;

  logic       start12;
  logic       ready12, busy12, done12;
  logic [7:0] d12;
  logic       cl12, le12, oe12, sph12, ckv12, spv12, gmode12;

  int n_chk  = 0;
  int n_fail = 0;

  epd_scan_ctrl #(
    .H_BYTES(T_H), .V_LINES(T_V), .CL_DIV(T_CL), .CKV_TICKS(T_CKV), .FRAME_W(8)
  ) u_dut (
    .clock(clock), .reset_n(reset_n), .start(start), .frames(frames),
    .pix_data(pix_data), .data_valid(data_valid), .data_ready(data_ready),
    .busy(busy), .done(done), .epd_d(epd_d), .epd_cl(epd_cl), .epd_le(epd_le),
    .epd_oe(epd_oe), .epd_sph(epd_sph), .epd_ckv(epd_ckv), .epd_spv(epd_spv),
    .epd_gmode(epd_gmode)
  );

  epd_scan_ctrl #(
    .H_BYTES(4), .V_LINES(2), .CL_DIV(12), .CKV_TICKS(2), .FRAME_W(8)
  ) u_dut12 (
    .clock(clock), .reset_n(reset_n), .start(start12), .frames(8'd1),
    .pix_data(8'hA5), .data_valid(1'b1), .data_ready(ready12),
    .busy(busy12), .done(done12), .epd_d(d12), .epd_cl(cl12), .epd_le(le12),
    .epd_oe(oe12), .epd_sph(sph12), .epd_ckv(ckv12), .epd_spv(spv12),
    .epd_gmode(gmode12)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  // Upstream source: 0 = always valid, 1 = random valid, 2 = 11/22/33/44 pattern with a 10-clock drop.
  int   src_mode  = 0;
  int   last_mode = -1;
  int   k         = 0;
  int   drop_left = 0;
  bit   dropped   = 0;
  bit   mon_take  = 0;

  initial begin
    pix_data   = 8'h00;
    data_valid = 1'b0;
  end

  always @(posedge clock) begin
    #1;
    if (src_mode != last_mode) begin
      last_mode = src_mode;
      k         = 0;
      dropped   = 0;
      drop_left = 0;
      pix_data  = (src_mode == 2) ? 8'h11 : 8'($urandom);
    end else if (mon_take) begin
      k++;
      pix_data = (src_mode == 2) ? 8'(8'h11 * ((k % 4) + 1)) : 8'($urandom);
    end
    case (src_mode)
      1: data_valid = ($urandom_range(0, 3) != 0);
      2: begin
        if (drop_left > 0) begin
          data_valid = 1'b0;
          drop_left--;
        end else if (!dropped && k == 2) begin
          dropped    = 1;
          drop_left  = 9;
          data_valid = 1'b0;
        end else begin
          data_valid = 1'b1;
        end
      end
      default: data_valid = 1'b1;
    endcase
  end

  // Output monitor: event counters, pulse widths and a byte scoreboard.
  int   cnt_ready = 0, cnt_clrise = 0, cnt_le = 0, cnt_ckv = 0, cnt_spv = 0;
  int   cnt_done = 0, cnt_busy = 0, cnt_oe = 0, cnt_ckv_hi = 0, cnt_sph_lo = 0;
  int   run_cl = 0, run_le = 0, run_spv = 0, line_byte = 0;
  bit   p_cl = 0, p_le = 0, p_spv = 1, p_ckv = 0, p_done = 0, p_take = 0, p_rst = 1;
  logic [7:0] p_epd_d = 8'h00;
  logic [7:0] sb_q[$];

  always @(negedge clock) begin
    if (!reset_n) begin
      sb_q.delete();
      line_byte = 0;
      run_cl = 0; run_le = 0; run_spv = 0;
      p_cl = 0; p_le = 0; p_spv = 1; p_ckv = 0; p_done = 0; p_take = 0;
      p_rst    = 1;
      mon_take = 0;
      p_epd_d  = epd_d;
    end else begin
      chk("gmode_eq_busy", epd_gmode, busy);
      chk("ready_needs_valid", data_ready & ~data_valid, 0);
      chk("ready_only_busy", data_ready & ~busy, 0);
      if (data_ready) begin
        cnt_ready++;
        sb_q.push_back(pix_data);
      end
      if (!p_rst) begin
        chk("cl_rise_after_ready", epd_cl & ~p_cl, p_take);
        if (!p_take) chk("epd_d_hold", epd_d, p_epd_d);
      end
      if (epd_cl && !p_cl) begin
        cnt_clrise++;
        if (sb_q.size() == 0) chk("sb_underflow", 1, 0);
        else chk("epd_d_order", epd_d, sb_q.pop_front());
        chk("byte_in_line_range", line_byte < T_H, 1);
        if (src_mode == 2) chk("byte_pattern", epd_d, 8'(8'h11 * (line_byte + 1)));
        line_byte++;
      end
      if (epd_le && !p_le) begin
        cnt_le++;
        chk("bytes_per_line", line_byte, T_H);
        line_byte = 0;
      end
      if (epd_cl) run_cl++;
      else if (p_cl) begin chk("cl_high_width", run_cl, T_CL); run_cl = 0; end
      if (epd_le) run_le++;
      else if (p_le) begin chk("le_width", run_le, T_CL); run_le = 0; end
      if (!epd_spv) run_spv++;
      else if (!p_spv) begin chk("spv_low_width", run_spv, T_CL); run_spv = 0; end
      if (!epd_spv && p_spv) cnt_spv++;
      if (epd_ckv && !p_ckv) cnt_ckv++;
      if (epd_ckv) cnt_ckv_hi++;
      if (epd_oe) cnt_oe++;
      if (!epd_sph) cnt_sph_lo++;
      if (busy) cnt_busy++;
      if (done) begin
        cnt_done++;
        chk("done_single_clock", p_done, 0);
      end
      p_cl = epd_cl; p_le = epd_le; p_spv = epd_spv; p_ckv = epd_ckv; p_done = done;
      p_take   = data_ready;
      mon_take = data_ready;
      p_epd_d  = epd_d;
      p_rst    = 0;
    end
  end

  task automatic check_idle(input string tag);
    chk({tag, "_cl"}, epd_cl, 0);
    chk({tag, "_le"}, epd_le, 0);
    chk({tag, "_oe"}, epd_oe, 0);
    chk({tag, "_ckv"}, epd_ckv, 0);
    chk({tag, "_gmode"}, epd_gmode, 0);
    chk({tag, "_spv"}, epd_spv, 1);
    chk({tag, "_sph"}, epd_sph, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ready"}, data_ready, 0);
  endtask

  // One refresh; expectations follow from frame count and geometry alone.
  task automatic run_refresh(input int fr, input int vmode, input bit toggle);
    int fe, s_ready, s_cl, s_le, s_ckv, s_spv, s_done, s_busy, s_oe, s_ckvhi, s_sph;
    fe       = (fr == 0) ? 1 : fr;
    src_mode = vmode;
    repeat (2) begin @(posedge clock); #1; end
    s_ready = cnt_ready; s_cl = cnt_clrise; s_le = cnt_le; s_ckv = cnt_ckv;
    s_spv = cnt_spv; s_done = cnt_done; s_busy = cnt_busy; s_oe = cnt_oe;
    s_ckvhi = cnt_ckv_hi; s_sph = cnt_sph_lo;
    frames = 8'(fr);
    start  = 1'b1;
    for (int i = 0; i < LIMIT; i++) begin
      @(posedge clock); #1;
      if (toggle && i >= 4 && i < 30) start = i[2];
      else if (i >= 1) start = 1'b0;
      if (cnt_done != s_done) break;
    end
    start = 1'b0;
    repeat (8) begin @(posedge clock); #1; end
    chk("done_count", cnt_done - s_done, 1);
    chk("idle_after", busy, 0);
    chk("ready_pulses", cnt_ready - s_ready, fe * T_V * T_H);
    chk("cl_rises", cnt_clrise - s_cl, fe * T_V * T_H);
    chk("le_pulses", cnt_le - s_le, fe * T_V);
    chk("ckv_pulses", cnt_ckv - s_ckv, fe * (T_V + 1));
    chk("spv_pulses", cnt_spv - s_spv, fe);
    chk("oe_clocks", cnt_oe - s_oe, fe * T_V * T_CKV * T_CL);
    if (vmode == 0) begin
      chk("busy_clocks", cnt_busy - s_busy, fe * T_TICKS * T_CL);
      chk("ckv_hi_clocks", cnt_ckv_hi - s_ckvhi, fe * (1 + T_V * T_CKV) * T_CL);
      chk("sph_lo_clocks", cnt_sph_lo - s_sph, fe * T_V * 2 * T_H * T_CL);
    end
  endtask

  // Default prescaler: cl period and le width measured in clocks.
  task automatic run_dut12();
    int  cyc, last_rise, lb, busy_c, done_c, le_run;
    bit  q_cl, q_le;
    cyc = 0; last_rise = 0; lb = 0; busy_c = 0; done_c = 0; le_run = 0;
    q_cl = 0; q_le = 0;
    @(posedge clock); #1;
    start12 = 1'b1;
    for (int i = 0; i < LIMIT && done_c == 0; i++) begin
      @(negedge clock);
      cyc++;
      if (i == 2) start12 = 1'b0;
      if (busy12) busy_c++;
      if (done12) done_c++;
      if (cl12 && !q_cl) begin
        if (lb > 0) chk("cl_period_24", cyc - last_rise, 24);
        last_rise = cyc;
        lb++;
      end
      if (le12) le_run++;
      else if (q_le) begin
        chk("le_width_12", le_run, 12);
        le_run = 0;
        lb     = 0;
      end
      q_cl = cl12;
      q_le = le12;
    end
    start12 = 1'b0;
    chk("dut12_done", done_c, 1);
    chk("dut12_busy_clocks", busy_c, 12 * (2 + 2 * (2 * 4 + 1 + 2 + 1) + 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s_busy, s_done, found;
    reset_n = 1'b0;
    start   = 1'b1;
    start12 = 1'b0;
    frames  = 8'd0;
    repeat (3) begin @(posedge clock); #1; end
    check_idle("reset");
    chk("reset_epd_d", epd_d, 0);

    // Start held high through reset must not launch.
    reset_n = 1'b1;
    s_busy  = cnt_busy;
    repeat (20) begin @(posedge clock); #1; end
    chk("held_start_no_launch", cnt_busy - s_busy, 0);
    chk("held_start_busy", busy, 0);
    start = 1'b0;
    repeat (3) begin @(posedge clock); #1; end

    run_refresh(1, 0, 0);
    run_refresh(0, 0, 0);
    run_refresh(3, 0, 0);
    run_refresh(1, 2, 0);
    run_refresh(1, 0, 1);

    // Abort during GATE.
    src_mode = 0;
    frames   = 8'd1;
    @(posedge clock); #1;
    start = 1'b1;
    found = 0;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clock);
      if (epd_oe && epd_ckv) begin found = 1; break; end
    end
    chk("reach_gate", found, 1);
    @(posedge clock); #1;
    start   = 1'b0;
    reset_n = 1'b0;
    s_done  = cnt_done;
    @(posedge clock); #1;
    check_idle("abort");
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (10) begin @(posedge clock); #1; end
    chk("abort_no_done", cnt_done - s_done, 0);
    run_refresh(2, 0, 0);

    for (int r = 0; r < 4; r++) run_refresh(int'($urandom_range(0, 3)), 1, 0);

    run_dut12();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/epd_scan_ctrl.md
Name: epd_scan_ctrl

Overview:
Frame/line scan sequencer for the e-paper panel. On a start request it drives the source-driver and gate-driver timing signals (CL, LE, OE, SPH, CKV, SPV, GMODE) for a programmable number of frames. It pulls one pixel byte per CL period from an upstream waveform/pixel source through a valid/ready handshake. All panel timing is derived from the single system clock by an internal tick prescaler that replaces free-running divided clocks, so no generated clocks exist in the design.

Parameters:
H_BYTES, 200, pixel bytes shifted per line (4 px/byte, 800 px).
V_LINES, 600, gate lines per frame.
CL_DIV, 12, system clocks per timing tick (tick = 1 clock every CL_DIV).
CKV_TICKS, 2, ticks CKV/OE stay high per line.
FRAME_W, 8, width of frame-count input.

Ports:
clock  in  1  system clock, all logic on posedge.
reset_n  in  1  synchronous active-low reset.
start  in  1  level request; rising edge (detected internally) launches a refresh.
frames  in  FRAME_W  frames per refresh, sampled on accepted start; 0 treated as 1.
pix_data  in  8  pixel byte from upstream.
data_valid  in  1  pix_data valid.
data_ready  out  1  1-cycle pulse: byte consumed this cycle.
busy  out  1  high from accepted start until done.
done  out  1  1-cycle pulse at end of refresh.
epd_d  out  8  source data bus.
epd_cl  out  1  source shift clock.
epd_le  out  1  source latch enable.
epd_oe  out  1  source output enable.
epd_sph  out  1  source start pulse, active low.
epd_ckv  out  1  gate clock.
epd_spv  out  1  gate start pulse, active low.
epd_gmode  out  1  gate mode, high while busy.

Behaviour:
- Reset (reset_n=0 at posedge): state IDLE, all counters 0. Outputs: cl=le=oe=ckv=gmode=0, spv=sph=1, epd_d=0, busy=done=data_ready=0. Mid-refresh reset aborts immediately: no done pulse, outputs at idle values the next edge.
- Start detection: start registered once; accept = start & ~start_q & state==IDLE. Edges while busy are ignored and not queued.
- Tick: prescaler counts 0..CL_DIV-1 while busy, tick=1 when count==CL_DIV-1. Cleared on accept. All state transitions below happen on tick cycles only, except the DONE->IDLE return.
- States:
  IDLE: wait for accept. Then latch frames (0->1), frame_cnt=0, busy=1, gmode=1, go FS1.
  FS1: spv=0, ckv=1 for 1 tick -> FS2.
  FS2: ckv=0, spv=1 for 1 tick. line_cnt=0 -> LD_A.
  LD_A (cl=0, sph=0): on tick with data_valid=1, latch pix_data into epd_d, data_ready=1 that cycle -> LD_B. With data_valid=0, stall; cl stays low, byte_cnt frozen, no timeout.
  LD_B (cl=1, sph=0): on tick cl->0, byte_cnt++. If byte_cnt reaches H_BYTES -> LATCH, sph=1, byte_cnt=0; else -> LD_A.
  LATCH: le=1 for 1 tick -> GATE.
  GATE: ckv=1, oe=1 for CKV_TICKS ticks -> GATE_LO.
  GATE_LO: ckv=0, oe=0 for 1 tick. line_cnt++; if line_cnt==V_LINES -> FE, else -> LD_A.
  FE: 1 tick. frame_cnt++; if frame_cnt==frames_latched -> DONE, else -> FS1.
  DONE: done=1, busy=0, gmode=0 for exactly 1 clock -> IDLE.
- data_ready is never high outside LD_A. epd_d holds its last value until the next byte is accepted; it returns to 0 only at reset.
- Counters are sized by $clog2 of their parameter and never wrap within a refresh.
- Unstalled tick count per frame: 2 + V_LINES*(2*H_BYTES + 1 + CKV_TICKS + 1) + 1.

Decomposition:
- Package epd_pkg holds: the state enum (IDLE, FS1, FS2, LD_A, LD_B, LATCH, GATE, GATE_LO, FE, DONE) and the idle output constants (SPV/SPH inactive = 1).
- Sub-module epd_tick_gen: prescaler with clear input and tick output, parameter CL_DIV.
- Edge detect and FSM stay in epd_scan_ctrl.

Test Plan:
- CL_DIV=2, H_BYTES=4, V_LINES=3, CKV_TICKS=2, frames=1, data_valid=1 held -> 12 data_ready pulses, 12 cl rising edges, 3 le pulses, 4 ckv pulses (1 FS1 + 3 GATE), spv low exactly 1 tick, busy high 78 clocks (+1 for edge detect), one done pulse.
- Same config, frames=0 -> identical to frames=1. frames=3 -> 3 spv low pulses, 36 data_ready pulses, done once after 3*39 ticks.
- data_valid dropped for 10 clocks mid-line -> cl stays 0, epd_d unchanged, no data_ready; resumes; still exactly 4 bytes per line and correct byte order (feed 0x11,0x22,0x33,0x44 -> epd_d shows them in order at cl rise).
- start toggled 0->1->0->1 while busy -> no second refresh and done pulses once. start held high from reset -> no launch until a fresh rising edge.
- reset_n=0 asserted during GATE -> next clock: ckv=oe=0, spv=sph=1, busy=0, no done. A subsequent start runs a complete refresh.
- CL_DIV=12 default -> cl period exactly 24 clocks with no stall; le pulse width exactly 12 clocks.
